// File: rtl/btn_pkg.sv
// btn_pkg: shared defaults and counter sizing for the button debouncer
package btn_pkg;
  localparam int DEBOUNCE_CYCLES_DEF = 50000;
  localparam int SYNC_STAGES_DEF = 2;
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/btn_debounce_ch.sv
// btn_debounce_ch: one button channel - synchronizer, stability counter, level and edge pulses
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic rise,
  output logic fall,
  output logic toggle
);
  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0] cnt;
  logic s;
  logic done;
  assign s = sync[SYNC_STAGES-1];
  // the counter tops out at DEBOUNCE_CYCLES-1, where the level flips and the count restarts
  assign done = (s != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync <= '0;
      cnt <= '0;
      level <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
      toggle <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], btn};
      cnt <= (s == level || done) ? '0 : cnt + CW'(1);
      level <= done ? s : level;
      rise <= done && s;
      fall <= done && !s;
      toggle <= toggle ^ (done && s);
    end
endmodule

// File: rtl/btn_debounce.sv
// btn_debounce: two independent debounced buttons plus a chord pulse
module btn_debounce
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_0,
  input  logic btn_1,
  output logic btn_0_level,
  output logic btn_1_level,
  output logic btn_0_press,
  output logic btn_1_press,
  output logic btn_0_release,
  output logic btn_1_release,
  output logic btn_0_toggle,
  output logic btn_1_toggle,
  output logic chord
);
  btn_debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_ch0 (
    .clk(clk), .rst(rst), .btn(btn_0),
    .level(btn_0_level), .rise(btn_0_press), .fall(btn_0_release), .toggle(btn_0_toggle)
  );
  btn_debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_ch1 (
    .clk(clk), .rst(rst), .btn(btn_1),
    .level(btn_1_level), .rise(btn_1_press), .fall(btn_1_release), .toggle(btn_1_toggle)
  );
  // the AND of both levels can only rise in a cycle where one channel presses
  assign chord = (btn_0_press || btn_1_press) && btn_0_level && btn_1_level;
endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: directed stimulus checked against a run-length model of the debouncer
module tb_btn_debounce;
  localparam int DC = 4;
  localparam int SS = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_0 = 1'b0;
  logic btn_1 = 1'b0;
  logic l0, l1, p0, p1, r0, r1, t0, t1, chord;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  btn_debounce #(.DEBOUNCE_CYCLES(DC), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .btn_0(btn_0), .btn_1(btn_1),
    .btn_0_level(l0), .btn_1_level(l1), .btn_0_press(p0), .btn_1_press(p1),
    .btn_0_release(r0), .btn_1_release(r1), .btn_0_toggle(t0), .btn_1_toggle(t1),
    .chord(chord)
  );
  typedef struct packed {
    logic lev;
    logic pr;
    logic rl;
    logic tg;
    logic [7:0] run;
  } ch_t;
  ch_t m0, m1;
  logic mchord;
  logic [SS-1:0] h0, h1;
  // a level changes once the delayed input has disagreed with it for DC consecutive edges
  function automatic ch_t step(input ch_t c, input logic s);
    ch_t n = c;
    n.pr = 1'b0;
    n.rl = 1'b0;
    n.run = (s != c.lev) ? c.run + 8'd1 : 8'd0;
    if (n.run == 8'(DC)) begin
      n.lev = s;
      n.run = 8'd0;
      n.pr = s;
      n.rl = !s;
      n.tg = c.tg ^ s;
    end
    return n;
  endfunction
  always @(posedge clk or posedge rst) begin : model
    ch_t n0, n1;
    if (rst) begin
      m0 <= '0;
      m1 <= '0;
      mchord <= 1'b0;
      h0 <= '0;
      h1 <= '0;
    end else begin
      n0 = step(m0, h0[SS-1]);
      n1 = step(m1, h1[SS-1]);
      m0 <= n0;
      m1 <= n1;
      mchord <= n0.lev && n1.lev && !(m0.lev && m1.lev);
      h0 <= {h0[SS-2:0], btn_0};
      h1 <= {h1[SS-2:0], btn_1};
    end
  end
  always @(negedge clk) begin
    logic [8:0] act, exp;
    act = {l0, p0, r0, t0, l1, p1, r1, t1, chord};
    exp = {m0.lev, m0.pr, m0.rl, m0.tg, m1.lev, m1.pr, m1.rl, m1.tg, mchord};
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL model_cmp t=%0t outputs=%b expected=%b", $time, act, exp);
    end
  end
  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    int pc, pi, cc, lc;
    tick(2);
    rst = 1'b0;
    tick(20);
    check("idle_outputs", int'({l0, p0, r0, t0, l1, p1, r1, t1, chord}), 0);
    btn_0 = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("b0_press_timing", int'(p0), int'(i == 6));
      check("b0_level_timing", int'(l0), int'(i >= 6));
    end
    check("b0_toggle_set", int'(t0), 1);
    btn_0 = 1'b0;
    tick(10);
    check("b0_toggle_kept", int'(t0), 1);
    btn_0 = 1'b1; tick();
    btn_0 = 1'b0; tick();
    btn_0 = 1'b1; tick();
    btn_0 = 1'b0; tick();
    btn_0 = 1'b1;
    pc = 0;
    pi = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (p0) begin pc++; pi = i; end
    end
    check("bounce_press_count", pc, 1);
    check("bounce_press_cycle", pi, 6);
    check("bounce_toggle", int'(t0), 0);
    btn_0 = 1'b0;
    tick(10);
    btn_1 = 1'b1;
    tick(3);
    btn_1 = 1'b0;
    lc = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (l1 || p1 || r1) lc++;
    end
    check("short_pulse_ignored", lc, 0);
    btn_0 = 1'b1;
    btn_1 = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 6) begin
        check("both_press0", int'(p0), 1);
        check("both_press1", int'(p1), 1);
        check("chord_pulse", int'(chord), 1);
      end
      if (i == 7) check("chord_one_cycle", int'(chord), 0);
    end
    btn_0 = 1'b0;
    cc = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (chord) cc++;
      if (i == 6) check("release0_pulse", int'(r0), 1);
    end
    check("chord_quiet_on_release", cc, 0);
    btn_1 = 1'b0;
    tick(10);
    btn_0 = 1'b1;
    btn_1 = 1'b1;
    tick(10);
    btn_1 = 1'b0;
    tick(4);
    check("pre_reset_level0", int'(l0), 1);
    #2 rst = 1'b1;
    #1 check("async_reset_clear", int'({l0, p0, r0, t0, l1, p1, r1, t1, chord}), 0);
    tick(2);
    rst = 1'b0;
    pc = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("post_reset_press0", int'(p0), int'(i == 6));
      if (l1 || p1 || r1) pc++;
    end
    check("post_reset_ch1_quiet", pc, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000, stable-sample count before accepting a level change (1 ms at 50 MHz); legal range 2..2^20.
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer flop count; legal range 2..3.
REQ-003 clk  input  1  single system clock, all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 btn_0  input  1  raw asynchronous button 0, active-high, may bounce.
REQ-006 btn_1  input  1  raw asynchronous button 1, active-high, may bounce.
REQ-007 btn_0_level, btn_1_level  output  1 each  debounced button level.
REQ-008 btn_0_press, btn_1_press  output  1 each  one-cycle pulse on debounced 0->1.
REQ-009 btn_0_release, btn_1_release  output  1 each  one-cycle pulse on debounced 1->0.
REQ-010 btn_0_toggle, btn_1_toggle  output  1 each  state bit flipped on every press.
REQ-011 chord  output  1  one-cycle pulse when both debounced levels become 1 in the same cycle or one becomes 1 while the other is already 1.

Function
REQ-012 Each raw input passes through SYNC_STAGES flops before any other use; no raw input reaches other logic.
REQ-013 Per channel, one counter of width clog2(DEBOUNCE_CYCLES); counter clears whenever synchronized input equals debounced level.
REQ-014 While synchronized input differs from level, counter increments by 1 per cycle; it never wraps.
REQ-015 When counter equals DEBOUNCE_CYCLES-1 and input still differs, level takes the input value and counter clears in the same cycle.
REQ-016 Any single-cycle return of synchronized input to level value clears the counter; the full window restarts.
REQ-017 Latency: clean raw edge at cycle 0 -> level change registered at cycle SYNC_STAGES+DEBOUNCE_CYCLES.
REQ-018 press/release pulses are registered, asserted exactly the cycle level changes, for exactly one cycle; never both high together.
REQ-019 toggle flips in the cycle press asserts; release does not affect it.
REQ-020 Channels are fully independent; simultaneous transitions on both produce both channels' pulses in the same cycle.
REQ-021 chord asserts for one cycle on the rising edge of (btn_0_level AND btn_1_level); held chord produces no further pulses.
REQ-022 Input pulses shorter than DEBOUNCE_CYCLES synchronized cycles produce no output change.

Reset
REQ-023 rst asserted: synchronizer flops, counters, levels, toggles, pulses, chord all 0 immediately, without clock.
REQ-024 rst deasserted with button held: level rises after full debounce window, producing one press pulse.
REQ-025 rst mid-window discards partial count; no pulse is emitted for that transition.

Structure
REQ-026 Shared package btn_pkg holds DEBOUNCE_CYCLES default, SYNC_STAGES default, and counter-width function.
REQ-027 Sub-module btn_debounce_ch (synchronizer, counter, level, press, release, toggle) instantiated twice; chord logic in top.
REQ-028 Implementation is 120-400 lines RTL total, no latches, no derived clocks.

Verification (bench uses DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
REQ-029 Reset release, inputs 0 for 20 cycles -> all outputs 0 throughout.
REQ-030 btn_0 0->1 held at cycle 0 -> btn_0_level=1 at cycle 6, btn_0_press high only cycle 6, btn_0_toggle=1 from cycle 6.
REQ-031 btn_0 bounce 1,0,1,0 per cycle then held 1 -> single press pulse, 6 cycles after last edge; toggle flips once.
REQ-032 btn_1 high for 3 cycles only -> no level change, no pulses.
REQ-033 Both buttons rise same cycle -> both press pulses and chord pulse same cycle; release btn_0 -> btn_0_release pulse, chord stays 0.
REQ-034 rst asserted asynchronously mid-window and while level=1 -> all outputs 0 before next clock edge; button held through deassertion -> press pulse 6 cycles later.
